// File: rtl/l2_norm_arbiter.sv
// rtl/l2_norm_arbiter.sv - round-robin packet arbiter in front of a shared L2-norm engine
//
// Purpose: grants one requester vector stream at a time to the engine input,
// remembers the order of forwarded packets in a tag FIFO, and routes each
// single-beat engine result back to the requester that owns it.
//
// Ports:
//   clk, rst          single clock; asynchronous active-high reset
//   s_tdata/tvalid/tlast/tready   NUM_REQ requester streams, slot i = s_tdata[64*i +: 64]
//   e_in_tdata/tvalid/tlast/tready  selected stream towards the engine
//   e_out_tdata/tvalid/tready       engine result stream, one beat per packet
//   r_tdata/tvalid/tready           NUM_REQ result streams, slot i = r_tdata[32*i +: 32]
//   busy              high while forwarding or while results are outstanding
//   err_orphan        sticky: engine offered a result with no outstanding packet
//   pkt_cnt           (only with L2_NORM_ARB_PKT_CNT_EN) per-requester 16-bit
//                     wrapping count of delivered results
//
// Optional feature macro: L2_NORM_ARB_PKT_CNT_EN

module l2_norm_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ*64-1:0]  s_tdata,
  input  logic [NUM_REQ-1:0]     s_tvalid,
  input  logic [NUM_REQ-1:0]     s_tlast,
  output logic [NUM_REQ-1:0]     s_tready,
  output logic [63:0]            e_in_tdata,
  output logic                   e_in_tvalid,
  output logic                   e_in_tlast,
  input  logic                   e_in_tready,
  input  logic [31:0]            e_out_tdata,
  input  logic                   e_out_tvalid,
  output logic                   e_out_tready,
  output logic [NUM_REQ*32-1:0]  r_tdata,
  output logic [NUM_REQ-1:0]     r_tvalid,
  input  logic [NUM_REQ-1:0]     r_tready,
`ifdef L2_NORM_ARB_PKT_CNT_EN
  output logic [NUM_REQ*16-1:0]  pkt_cnt,
`endif
  output logic                   busy,
  output logic                   err_orphan
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(TAG_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FWD  = 1'b1;

  logic [0:0]    r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last_grant;
  logic [GW-1:0] r_tags [TAG_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_err_orphan;

  logic          w_fwd;
  logic          w_found;
  logic [GW-1:0] w_cand;
  logic [GW-1:0] w_pick;
  logic          w_grant_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [GW-1:0] w_head;

  assign w_fwd   = (r_state == ST_FWD);
  assign w_empty = (r_count == '0);
  assign w_head  = r_tags[r_rd_ptr];

  // Round-robin search starting just after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = GW'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && s_tvalid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // A full tag FIFO only blocks new grants; a packet already granted can
  // always push because the count cannot grow while it is in flight.
  assign w_grant_ok = (r_state == ST_IDLE) && w_found && (r_count < DEPTH);

  assign e_in_tdata  = s_tdata[64*r_grant +: 64];
  assign e_in_tvalid = w_fwd && s_tvalid[r_grant];
  assign e_in_tlast  = w_fwd && s_tlast[r_grant];

  always_comb begin
    s_tready = '0;
    if (w_fwd) s_tready[r_grant] = e_in_tready;
  end

  assign w_push = e_in_tvalid && e_in_tready && e_in_tlast;

  // Results always belong to the oldest outstanding packet.
  always_comb begin
    r_tvalid     = '0;
    r_tdata      = '0;
    e_out_tready = 1'b0;
    if (!w_empty) begin
      r_tvalid[w_head]          = e_out_tvalid;
      r_tdata[32*w_head +: 32]  = e_out_tdata;
      e_out_tready              = r_tready[w_head];
    end
  end

  assign w_pop = e_out_tvalid && e_out_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_ok) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_state      <= ST_FWD;
          end
        end
        default: begin
          if (w_push) r_state <= ST_IDLE;
        end
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (e_out_tvalid && w_empty) r_err_orphan <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read behind the count.
  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wr_ptr] <= r_grant;
  end

  assign busy       = w_fwd || !w_empty;
  assign err_orphan = r_err_orphan;

`ifdef L2_NORM_ARB_PKT_CNT_EN
  logic [NUM_REQ*16-1:0] r_pkt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else if (w_pop) begin
      r_pkt_cnt[16*w_head +: 16] <= r_pkt_cnt[16*w_head +: 16] + 16'd1;
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_l2_norm_arbiter.sv
// tb/tb_l2_norm_arbiter.sv - directed self-checking bench for l2_norm_arbiter

module tb_l2_norm_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] s_tdata = '0;
  logic [1:0]   s_tvalid = '0;
  logic [1:0]   s_tlast = '0;
  logic [1:0]   s_tready;
  logic [63:0]  e_in_tdata;
  logic         e_in_tvalid;
  logic         e_in_tlast;
  logic         e_in_tready = 1'b0;
  logic [31:0]  e_out_tdata = '0;
  logic         e_out_tvalid = 1'b0;
  logic         e_out_tready;
  logic [63:0]  r_tdata;
  logic [1:0]   r_tvalid;
  logic [1:0]   r_tready = '0;
  logic         busy;
  logic         err_orphan;
`ifdef L2_NORM_ARB_PKT_CNT_EN
  logic [31:0]  pkt_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_norm_arbiter #(.NUM_REQ(2), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .e_in_tdata(e_in_tdata), .e_in_tvalid(e_in_tvalid), .e_in_tlast(e_in_tlast),
    .e_in_tready(e_in_tready),
    .e_out_tdata(e_out_tdata), .e_out_tvalid(e_out_tvalid), .e_out_tready(e_out_tready),
    .r_tdata(r_tdata), .r_tvalid(r_tvalid), .r_tready(r_tready),
`ifdef L2_NORM_ARB_PKT_CNT_EN
    .pkt_cnt(pkt_cnt),
`endif
    .busy(busy), .err_orphan(err_orphan)
  );

  task automatic test_reset();
    rst = 1'b1;
    s_tvalid = 2'b11;
    e_out_tvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (s_tready !== 2'b00 || e_in_tvalid !== 1'b0 || e_out_tready !== 1'b0 ||
        r_tvalid !== 2'b00 || busy !== 1'b0 || err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got s_tready=%b e_in_tvalid=%b e_out_tready=%b r_tvalid=%b busy=%b err=%b exp all 0",
               s_tready, e_in_tvalid, e_out_tready, r_tvalid, busy, err_orphan);
    end
    s_tvalid = 2'b00;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || s_tready !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b s_tready=%b exp 0 00", busy, s_tready);
    end
  endtask

  task automatic test_alternate();
    int bc[2];
    int grants[$];
    int idle_between;
    int beats;
    int g;
    bit started;
    bit acc;
    bc = '{0, 0};
    idle_between = 0;
    beats = 0;
    g = 0;
    started = 1'b0;
    s_tvalid = 2'b11;
    e_in_tready = 1'b1;
    for (int cyc = 0; cyc < 40 && grants.size() < 4; cyc++) begin
      s_tdata = {32'd1, 32'(bc[1]), 32'd0, 32'(bc[0])};
      s_tlast = {bc[1] == 2, bc[0] == 2};
      #1;
      acc = 1'b0;
      if (e_in_tvalid) begin
        started = 1'b1;
        g = s_tready[1] ? 1 : 0;
        checks++;
        if (s_tready !== (2'b01 << g)) begin
          errors++;
          $display("FAIL alt_tready got %b exp %b", s_tready, 2'b01 << g);
        end
        checks++;
        if (e_in_tdata !== {32'(g), 32'(bc[g])}) begin
          errors++;
          $display("FAIL alt_tdata got %h exp %h", e_in_tdata, {32'(g), 32'(bc[g])});
        end
        if (e_in_tlast) grants.push_back(g);
        acc = 1'b1;
        beats++;
      end else if (started) begin
        idle_between++;
      end
      @(posedge clk); #1;
      if (acc) bc[g] = (bc[g] + 1) % 3;
    end
    s_tvalid = 2'b00;
    checks++;
    if (grants.size() != 4 || beats != 12) begin
      errors++;
      $display("FAIL alt_count got packets=%0d beats=%0d exp 4 12", grants.size(), beats);
    end
    for (int k = 0; k < grants.size(); k++) begin
      checks++;
      if (grants[k] != k % 2) begin
        errors++;
        $display("FAIL alt_grant_order idx %0d got %0d exp %0d", k, grants[k], k % 2);
      end
    end
    checks++;
    if (idle_between != 3) begin
      errors++;
      $display("FAIL alt_idle_gap got %0d exp 3", idle_between);
    end
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL alt_busy_pending got %b exp 1", busy);
    end
    // Head result belongs to requester 0; its ready must gate the engine.
    e_out_tvalid = 1'b1;
    e_out_tdata = 32'h100;
    r_tready = 2'b10;
    #1;
    checks++;
    if (e_out_tready !== 1'b0) begin
      errors++;
      $display("FAIL alt_stall_ready got %b exp 0", e_out_tready);
    end
    r_tready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      e_out_tdata = 32'h100 + 32'(k);
      #1;
      checks++;
      if (r_tvalid !== (2'b01 << (k % 2)) || e_out_tready !== 1'b1) begin
        errors++;
        $display("FAIL alt_route idx %0d got r_tvalid=%b e_out_tready=%b exp %b 1",
                 k, r_tvalid, e_out_tready, 2'b01 << (k % 2));
      end
      checks++;
      if (r_tdata !== ((k % 2 == 0) ? {32'd0, 32'h100 + 32'(k)} : {32'h100 + 32'(k), 32'd0})) begin
        errors++;
        $display("FAIL alt_rdata idx %0d got %h", k, r_tdata);
      end
      @(posedge clk); #1;
    end
    e_out_tvalid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL alt_drained got busy=%b err=%b exp 0 0", busy, err_orphan);
    end
`ifdef L2_NORM_ARB_PKT_CNT_EN
    checks++;
    if (pkt_cnt !== {16'd2, 16'd2}) begin
      errors++;
      $display("FAIL alt_pkt_cnt got %h exp %h", pkt_cnt, {16'd2, 16'd2});
    end
`endif
  endtask

  task automatic test_single();
    int bc;
    int npkt;
    bit acc;
    bit r0_seen;
    bc = 0;
    npkt = 0;
    r0_seen = 1'b0;
    s_tvalid = 2'b10;
    e_in_tready = 1'b1;
    for (int cyc = 0; cyc < 20 && npkt < 2; cyc++) begin
      s_tdata = {32'd1, 32'(bc), 64'd0};
      s_tlast = {bc == 1, 1'b0};
      #1;
      acc = 1'b0;
      if (e_in_tvalid) begin
        checks++;
        if (s_tready !== 2'b10) begin
          errors++;
          $display("FAIL single_tready got %b exp 10", s_tready);
        end
        if (e_in_tlast) npkt++;
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) bc = (bc + 1) % 2;
    end
    s_tvalid = 2'b00;
    checks++;
    if (npkt != 2) begin
      errors++;
      $display("FAIL single_packets got %0d exp 2", npkt);
    end
    e_out_tvalid = 1'b1;
    r_tready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      e_out_tdata = 32'hA0 + 32'(k);
      #1;
      if (r_tvalid[0]) r0_seen = 1'b1;
      checks++;
      if (r_tvalid !== 2'b10 || r_tdata !== {32'hA0 + 32'(k), 32'd0}) begin
        errors++;
        $display("FAIL single_route idx %0d got r_tvalid=%b r_tdata=%h", k, r_tvalid, r_tdata);
      end
      @(posedge clk); #1;
    end
    e_out_tvalid = 1'b0;
    checks++;
    if (r0_seen) begin
      errors++;
      $display("FAIL single_r0_quiet got 1 exp 0");
    end
  endtask

  task automatic test_full();
    int n;
    s_tvalid = 2'b01;
    s_tlast = 2'b01;
    s_tdata = {64'd0, 64'hF00D};
    e_in_tready = 1'b1;
    e_out_tvalid = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (s_tready[0]) n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL full_grants got %0d exp 4", n);
    end
    checks++;
    if (s_tready !== 2'b00 || e_in_tvalid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_blocked got s_tready=%b e_in_tvalid=%b busy=%b exp 00 0 1",
               s_tready, e_in_tvalid, busy);
    end
    e_out_tvalid = 1'b1;
    e_out_tdata = 32'h55;
    r_tready = 2'b01;
    #1;
    checks++;
    if (e_out_tready !== 1'b1 || r_tvalid !== 2'b01) begin
      errors++;
      $display("FAIL full_pop got e_out_tready=%b r_tvalid=%b exp 1 01", e_out_tready, r_tvalid);
    end
    @(posedge clk); #1;
    e_out_tvalid = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      if (s_tready[0]) n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL full_refill got %0d exp 1", n);
    end
    s_tvalid = 2'b00;
    e_out_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (r_tvalid !== 2'b01) begin
        errors++;
        $display("FAIL full_drain idx %0d got %b exp 01", k, r_tvalid);
      end
      @(posedge clk); #1;
    end
    e_out_tvalid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL full_empty_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_orphan();
    e_out_tvalid = 1'b1;
    e_out_tdata = 32'hDEAD;
    r_tready = 2'b11;
    #1;
    checks++;
    if (e_out_tready !== 1'b0 || r_tvalid !== 2'b00 || r_tdata !== 64'd0) begin
      errors++;
      $display("FAIL orphan_block got e_out_tready=%b r_tvalid=%b r_tdata=%h exp 0 00 0",
               e_out_tready, r_tvalid, r_tdata);
    end
    @(posedge clk); #1;
    e_out_tvalid = 1'b0;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan_set got %b exp 1", err_orphan);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan_sticky got %b exp 1", err_orphan);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL orphan_clear got %b exp 0", err_orphan);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bc;
    bc = 0;
    s_tvalid = 2'b01;
    e_in_tready = 1'b1;
    for (int cyc = 0; cyc < 10 && bc < 1; cyc++) begin
      s_tdata = {64'd0, 32'd0, 32'(bc)};
      s_tlast = {1'b0, bc == 3};
      #1;
      @(posedge clk); #1;
      if (e_in_tvalid === 1'b1 || s_tready[0]) bc++;
    end
    s_tdata = {64'd0, 32'd0, 32'(bc)};
    s_tlast = 2'b00;
    #1;
    checks++;
    if (e_in_tvalid !== 1'b1 || e_in_tdata !== 64'd1) begin
      errors++;
      $display("FAIL mid_beat2 got e_in_tvalid=%b e_in_tdata=%h exp 1 1", e_in_tvalid, e_in_tdata);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (s_tready !== 2'b00 || e_in_tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got s_tready=%b e_in_tvalid=%b busy=%b exp 00 0 0",
               s_tready, e_in_tvalid, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    s_tvalid = 2'b11;
    s_tlast = 2'b11;
    @(posedge clk); #1;
    checks++;
    if (s_tready !== 2'b01) begin
      errors++;
      $display("FAIL mid_regrant got %b exp 01", s_tready);
    end
    s_tvalid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_full();
    test_orphan();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_norm_arbiter.md
L2_NORM_ARBITER -- requirements
Module: l2_norm_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requester streams (2..4).
REQ-002 SHALL have parameter TAG_DEPTH, default 4, result-routing tag FIFO depth (power of 2, >=2).
REQ-003 SHALL have clock  input  1  single clock, all state on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have s_tdata/s_tvalid/s_tlast  input  NUM_REQ*64/NUM_REQ/NUM_REQ  requester vector streams, slot i at bits [64*i+63:64*i].
REQ-006 SHALL have s_tready  output  NUM_REQ  per-requester accept.
REQ-007 SHALL have e_in_tdata/e_in_tvalid/e_in_tlast  output  64/1/1  stream to the L2-norm engine; e_in_tready  input  1.
REQ-008 SHALL have e_out_tdata  input  32, e_out_tvalid  input  1, e_out_tready  output  1  engine result stream (one beat per packet).
REQ-009 SHALL have r_tdata/r_tvalid  output  NUM_REQ*32/NUM_REQ, r_tready  input  NUM_REQ  per-requester result streams.
REQ-010 SHALL have busy  output  1  high when state is FWD or tag FIFO non-empty; err_orphan  output  1  sticky.

Function
REQ-011 SHALL implement FSM states IDLE and FWD.
REQ-012 In IDLE, if any s_tvalid and tag FIFO count < TAG_DEPTH, SHALL select the first valid requester after last_grant in round-robin order, register it as grant, update last_grant, go FWD next cycle; otherwise stay IDLE.
REQ-013 In IDLE all s_tready and e_in_tvalid SHALL be 0.
REQ-014 In FWD, e_in_tdata/tvalid/tlast SHALL equal slot grant combinationally; s_tready[grant] = e_in_tready; all other s_tready = 0.
REQ-015 On an accepted FWD beat with tlast=1, SHALL push grant into tag FIFO and return to IDLE next cycle; no other requester is granted mid-packet.
REQ-016 Result routing: with tag FIFO non-empty and head tag h, r_tvalid[h] = e_out_tvalid, r_tdata slot h = e_out_tdata, e_out_tready = r_tready[h]; other r_tvalid = 0.
REQ-017 On e_out handshake SHALL pop tag FIFO; simultaneous push and pop SHALL leave count unchanged.
REQ-018 With tag FIFO empty, e_out_tready SHALL be 0; if e_out_tvalid is high then, err_orphan SHALL set to 1 and hold until reset.
REQ-019 Arbitration-side latency: first beat of a granted packet reaches e_in no earlier than one cycle after IDLE decision; packet throughput penalty is exactly one IDLE cycle per packet.
REQ-020 Full tag FIFO SHALL block new grants only; an in-progress packet always completes and its push always succeeds.
REQ-021 r_tdata slots not selected SHALL be driven 0.

Reset
REQ-022 On reset assertion, SHALL immediately enter IDLE, clear tag FIFO, set last_grant = NUM_REQ-1 (requester 0 wins first), clear err_orphan and counters.
REQ-023 During and after reset all s_tready, e_in_tvalid, e_out_tready, r_tvalid, busy SHALL be 0 until a new grant; a partially forwarded packet is abandoned.

Configuration
REQ-024 Macro L2_NORM_ARB_PKT_CNT_EN defined: SHALL add output pkt_cnt NUM_REQ*16, per-requester count of completed result handshakes, wrapping 16'hFFFF -> 0.
REQ-025 Macro undefined: pkt_cnt port and counters SHALL not exist; all other behaviour identical.

Verification
REQ-026 Both requesters valid continuously, 3-beat packets -> grants alternate 0,1,0,1; results returned to r0,r1,r0,r1 in order.
REQ-027 Only requester 1 valid, 2 packets -> both granted to 1; r_tvalid[0] never asserted.
REQ-028 Engine results stalled, 5 single-beat packets offered, TAG_DEPTH=4 -> 4 grants, 5th blocked (s_tready=0) until one result popped.
REQ-029 e_out_tvalid=1 with empty tag FIFO -> e_out_tready=0, err_orphan=1 held until reset.
REQ-030 Reset asserted mid-packet (beat 2 of 4) -> s_tready=0 immediately, busy=0, next grant goes to requester 0.
REQ-031 With L2_NORM_ARB_PKT_CNT_EN, 65537 results to r0 -> pkt_cnt slot 0 = 1.
